// File: rtl/fleet_pkg.sv
// Shared types and widths for the enemy fleet formation controller.
package fleet_pkg;
  localparam int PIX_W  = 10;
  localparam int EDGE_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    MARCH,
    DROP,
    LANDED,
    CLEARED
  } fleet_state_e;
endpackage

// File: rtl/fleet_col_scan.sv
// Column scanner: lowest/highest alive column and the first alive column at or
// after a rotating pointer (wrapping), all combinational.
module fleet_col_scan #(
  parameter int cols_p = 8
) (
  input  logic [cols_p-1:0]         alive,
  input  logic [$clog2(cols_p)-1:0] ptr,
  output logic [$clog2(cols_p)-1:0] lo,
  output logic [$clog2(cols_p)-1:0] hi,
  output logic [$clog2(cols_p)-1:0] rr_col,
  output logic                      rr_found
);
  localparam int CW = $clog2(cols_p);

  logic [CW-1:0] idx;

  always_comb begin
    lo       = '0;
    hi       = '0;
    rr_col   = ptr;
    rr_found = 1'b0;
    idx      = '0;
    for (int c = cols_p - 1; c >= 0; c--) if (alive[c]) lo = CW'(c);
    for (int c = 0; c < cols_p; c++) if (alive[c]) hi = CW'(c);
    // Scan backwards so the nearest column after ptr wins; the add wraps mod cols_p.
    for (int k = cols_p - 1; k >= 0; k--) begin
      idx = ptr + CW'(k);
      if (alive[idx]) begin
        rr_col   = idx;
        rr_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fleet_march_ctrl.sv
// Enemy fleet formation controller: march/bounce/drop timing, landing and clear
// detection, round-robin fire scheduling. Optional FLEET_SPEEDUP_EN scales step period with live columns.
module fleet_march_ctrl
  import fleet_pkg::*;
#(
  parameter int cols_p            = 8,
  parameter int col_pitch_p       = 60,
  parameter int ship_w_p          = 40,
  parameter int left_start_p      = 9,
  parameter int top_start_p       = 9,
  parameter int screen_w_p        = 640,
  parameter int step_px_p         = 10,
  parameter int drop_px_p         = 10,
  parameter int land_y_p          = 440,
  parameter int frames_per_step_p = 30,
  parameter int fire_gap_p        = 90
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      start_i,
  input  logic                      frame_i,
  input  logic [cols_p-1:0]         col_alive_i,
  input  logic [9:0]                bot_off_i,
  output logic [9:0]                x_o,
  output logic [9:0]                y_o,
  output logic                      dir_right_o,
  output logic                      step_o,
  output logic                      fire_valid_o,
  output logic [$clog2(cols_p)-1:0] fire_col_o,
  input  logic                      fire_ready_i,
  output logic                      landed_o,
  output logic                      cleared_o,
  output logic                      active_o
);
  localparam int CW = $clog2(cols_p);
  localparam int FW = $clog2(frames_per_step_p + 1);
  localparam int GW = $clog2(fire_gap_p + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(fire_gap_p - 1);

  fleet_state_e state_q, state_d;
  logic [PIX_W-1:0]  x_q, y_q;
  logic              dir_q, step_q, pend_q;
  logic [FW-1:0]     fc_q, step_last;
  logic [GW-1:0]     gap_q;
  logic [CW-1:0]     ptr_q, col_q, lo, hi, rr_col;
  logic              rr_found;
  logic [EDGE_W-1:0] left_edge, right_edge;
  logic              active, landing, clear, run, restart, tick, bounce;

  fleet_col_scan #(.cols_p(cols_p)) u_scan (
    .alive    (col_alive_i),
    .ptr      (ptr_q),
    .lo       (lo),
    .hi       (hi),
    .rr_col   (rr_col),
    .rr_found (rr_found)
  );

  assign active     = (state_q == MARCH) || (state_q == DROP);
  assign landing    = ({1'b0, y_q} + {1'b0, bot_off_i}) >= EDGE_W'(land_y_p);
  assign clear      = (col_alive_i == '0);
  assign run        = active && !landing && !clear;
  assign restart    = !active && start_i;
  assign tick       = run && frame_i && (fc_q == step_last);
  assign left_edge  = {1'b0, x_q} + EDGE_W'(lo) * EDGE_W'(col_pitch_p);
  assign right_edge = {1'b0, x_q} + EDGE_W'(hi) * EDGE_W'(col_pitch_p) + EDGE_W'(ship_w_p);
  assign bounce     = dir_q ? (right_edge + EDGE_W'(step_px_p) > EDGE_W'(screen_w_p))
                            : (left_edge < EDGE_W'(step_px_p));

`ifdef FLEET_SPEEDUP_EN
  logic [FW-1:0] period_q, period_d;
  int unsigned   alive_n, period_calc;

  always_comb begin
    alive_n = 0;
    for (int c = 0; c < cols_p; c++) if (col_alive_i[c]) alive_n = alive_n + 1;
    period_calc = ($unsigned(frames_per_step_p) * alive_n) / $unsigned(cols_p);
    if (period_calc == 0) period_calc = 1;
    period_d = FW'(period_calc);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)    period_q <= FW'(frames_per_step_p);
    else if (restart) period_q <= FW'(frames_per_step_p);
    else if (tick)    period_q <= period_d;
  end

  assign step_last = period_q - FW'(1);
`else
  assign step_last = FW'(frames_per_step_p - 1);
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Landing outranks clear, and both outrank the step tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, LANDED, CLEARED: if (start_i) state_d = MARCH;
      MARCH: begin
        if (landing)             state_d = LANDED;
        else if (clear)          state_d = CLEARED;
        else if (tick && bounce) state_d = DROP;
      end
      DROP: begin
        if (landing)    state_d = LANDED;
        else if (clear) state_d = CLEARED;
        else if (tick)  state_d = MARCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      x_q    <= PIX_W'(left_start_p);
      y_q    <= PIX_W'(top_start_p);
      dir_q  <= 1'b1;
      step_q <= 1'b0;
      fc_q   <= '0;
      gap_q  <= '0;
      ptr_q  <= '0;
      pend_q <= 1'b0;
      col_q  <= '0;
    end else begin
      step_q <= 1'b0;
      if (restart) begin
        x_q    <= PIX_W'(left_start_p);
        y_q    <= PIX_W'(top_start_p);
        dir_q  <= 1'b1;
        fc_q   <= '0;
        gap_q  <= '0;
        ptr_q  <= '0;
        pend_q <= 1'b0;
      end else if (run) begin
        if (frame_i) fc_q <= tick ? '0 : fc_q + FW'(1);
        if (tick && state_q == DROP) begin
          y_q    <= y_q + PIX_W'(drop_px_p);
          dir_q  <= !dir_q;
          step_q <= 1'b1;
        end else if (tick && !bounce) begin
          x_q    <= dir_q ? x_q + PIX_W'(step_px_p) : x_q - PIX_W'(step_px_p);
          step_q <= 1'b1;
        end
        // Gap saturates at its threshold; a pending request keeps its column even if it dies.
        if (pend_q && fire_ready_i) begin
          pend_q <= 1'b0;
          ptr_q  <= col_q + CW'(1);
          gap_q  <= '0;
        end else begin
          if (frame_i && gap_q < GAP_LAST) gap_q <= gap_q + GW'(1);
          if (!pend_q && gap_q >= GAP_LAST && rr_found) begin
            pend_q <= 1'b1;
            col_q  <= rr_col;
          end
        end
      end else begin
        pend_q <= 1'b0;
      end
    end
  end

  always_comb begin
    x_o          = x_q;
    y_o          = y_q;
    dir_right_o  = dir_q;
    step_o       = step_q;
    fire_valid_o = pend_q && active;
    fire_col_o   = col_q;
    landed_o     = (state_q == LANDED);
    cleared_o    = (state_q == CLEARED);
    active_o     = active;
  end
endmodule

// File: tb/tb_fleet_march_ctrl.sv
// Bench for fleet_march_ctrl: random frame/ready stimulus against a behavioural
// model of the formation rules, plus directed bounce, landing, fire and reset steps.
module tb_fleet_march_ctrl;
  localparam int COLS = 8, P = 60, W = 40, LS = 9, TS = 9, SW = 640;
  localparam int S = 10, D = 10, LAND = 440, FPS = 2, FG = 3;
  localparam int M_IDLE = 0, M_MARCH = 1, M_DROP = 2, M_LANDED = 3, M_CLEARED = 4;

  logic       clk_i = 1'b0, reset_ni = 1'b1, start_i = 1'b0, frame_i = 1'b0, fire_ready_i = 1'b0;
  logic [7:0] col_alive_i = '0;
  logic [9:0] bot_off_i = '0;
  logic [9:0] x_o, y_o;
  logic [2:0] fire_col_o;
  logic       dir_right_o, step_o, fire_valid_o, landed_o, cleared_o, active_o;

  int n_checks = 0, n_err = 0;

  fleet_march_ctrl #(.frames_per_step_p(FPS), .fire_gap_p(FG)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .frame_i(frame_i),
    .col_alive_i(col_alive_i), .bot_off_i(bot_off_i), .x_o(x_o), .y_o(y_o),
    .dir_right_o(dir_right_o), .step_o(step_o), .fire_valid_o(fire_valid_o),
    .fire_col_o(fire_col_o), .fire_ready_i(fire_ready_i), .landed_o(landed_o),
    .cleared_o(cleared_o), .active_o(active_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int lowest(input logic [7:0] v);
    for (int c = 0; c < COLS; c++) if (v[c]) return c;
    return 0;
  endfunction

  function automatic int highest(input logic [7:0] v);
    for (int c = COLS - 1; c >= 0; c--) if (v[c]) return c;
    return 0;
  endfunction

  function automatic int first_from(input logic [7:0] v, input int p);
    for (int k = 0; k < COLS; k++) if (v[(p + k) % COLS]) return (p + k) % COLS;
    return p;
  endfunction

  // Behavioural model of the formation rules.
  int m_mode, m_x, m_y, m_fc, m_gap, m_ptr, m_col;
  bit m_dir, m_step, m_pend, mt_tick;

  always @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      m_mode <= M_IDLE; m_x <= LS; m_y <= TS; m_dir <= 1'b1; m_step <= 1'b0;
      m_fc <= 0; m_gap <= 0; m_ptr <= 0; m_pend <= 1'b0; m_col <= 0;
    end else begin
      m_step <= 1'b0;
      if (m_mode == M_MARCH || m_mode == M_DROP) begin
        if (m_y + int'(bot_off_i) >= LAND) begin
          m_mode <= M_LANDED; m_pend <= 1'b0;
        end else if (col_alive_i == 0) begin
          m_mode <= M_CLEARED; m_pend <= 1'b0;
        end else begin
          mt_tick = 1'b0;
          if (frame_i) begin
            if (m_fc == FPS - 1) begin mt_tick = 1'b1; m_fc <= 0; end
            else m_fc <= m_fc + 1;
          end
          if (mt_tick && m_mode == M_DROP) begin
            m_y <= m_y + D; m_dir <= !m_dir; m_step <= 1'b1; m_mode <= M_MARCH;
          end else if (mt_tick) begin
            if (m_dir ? (m_x + highest(col_alive_i) * P + W + S > SW)
                      : (m_x + lowest(col_alive_i) * P < S))
              m_mode <= M_DROP;
            else begin
              m_x <= m_dir ? m_x + S : m_x - S; m_step <= 1'b1;
            end
          end
          if (m_pend && fire_ready_i) begin
            m_pend <= 1'b0; m_ptr <= (m_col + 1) % COLS; m_gap <= 0;
          end else begin
            if (frame_i) m_gap <= m_gap + 1;
            if (!m_pend && m_gap >= FG - 1) begin
              m_pend <= 1'b1; m_col <= first_from(col_alive_i, m_ptr);
            end
          end
        end
      end else if (start_i) begin
        m_mode <= M_MARCH; m_x <= LS; m_y <= TS; m_dir <= 1'b1;
        m_fc <= 0; m_gap <= 0; m_ptr <= 0; m_pend <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i); #1;
    chk("x", int'(x_o), m_x);
    chk("y", int'(y_o), m_y);
    chk("dir", int'(dir_right_o), int'(m_dir));
    chk("step", int'(step_o), int'(m_step));
    chk("fire_valid", int'(fire_valid_o), int'(m_pend));
    if (m_pend) chk("fire_col", int'(fire_col_o), m_col);
    chk("landed", int'(landed_o), int'(m_mode == M_LANDED));
    chk("cleared", int'(cleared_o), int'(m_mode == M_CLEARED));
    chk("active", int'(active_o), int'(m_mode == M_MARCH || m_mode == M_DROP));
  endtask

  task automatic rand_in();
    frame_i      = ($urandom_range(0, 3) != 0);
    fire_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_x"}, int'(x_o), LS);
    chk({pfx, "_y"}, int'(y_o), TS);
    chk({pfx, "_dir"}, int'(dir_right_o), 1);
    chk({pfx, "_step"}, int'(step_o), 0);
    chk({pfx, "_valid"}, int'(fire_valid_o), 0);
    chk({pfx, "_landed"}, int'(landed_o), 0);
    chk({pfx, "_cleared"}, int'(cleared_o), 0);
    chk({pfx, "_active"}, int'(active_o), 0);
  endtask

  initial begin
    int n;
    int got[$];
    int exp_cols[3];
    exp_cols = '{5, 7, 5};

    #1 reset_ni = 1'b0;
    #1 chk_reset_vals("rst");
    @(negedge clk_i) reset_ni = 1'b1;
    cyc();

    // All alive: march right, bounce once the next step would cross the border.
    col_alive_i = 8'hFF; bot_off_i = 10'd30; frame_i = 1'b0;
    start_i = 1'b1; cyc(); start_i = 1'b0;
    chk("start_active", int'(active_o), 1);
    n = 0;
    while (dir_right_o !== 1'b0 && n < 2000) begin rand_in(); cyc(); n++; end
    chk("bounce_r_wait", int'(n < 2000), 1);
    chk("bounce_r_x", int'(x_o), 179);
    chk("bounce_r_y", int'(y_o), 19);
    repeat (30) begin rand_in(); cyc(); end

    // Clear, then restart with only column 0 alive.
    col_alive_i = 8'h00; cyc();
    chk("clear_flag", int'(cleared_o), 1);
    chk("clear_inactive", int'(active_o), 0);
    col_alive_i = 8'h01; start_i = 1'b1; cyc(); start_i = 1'b0;
    chk("restart1_x", int'(x_o), LS);
    chk("restart1_y", int'(y_o), TS);
    n = 0;
    while (dir_right_o !== 1'b0 && n < 3000) begin rand_in(); cyc(); n++; end
    chk("single_wait", int'(n < 3000), 1);
    chk("single_bounce_x", int'(x_o), 599);

    // Landing after the next drop.
    bot_off_i = 10'd420;
    n = 0;
    while (landed_o !== 1'b1 && n < 3000) begin rand_in(); cyc(); n++; end
    chk("land_wait", int'(n < 3000), 1);
    chk("land_y", int'(y_o), 29);
    chk("land_x", int'(x_o), 9);
    chk("land_no_fire", int'(fire_valid_o), 0);
    repeat (4) begin rand_in(); cyc(); end

    // Restart into fire scheduling with columns 5 and 7 alive.
    col_alive_i = 8'hA0; bot_off_i = 10'd0; fire_ready_i = 1'b0;
    start_i = 1'b1; cyc(); start_i = 1'b0;
    chk("restart2_x", int'(x_o), LS);
    chk("restart2_active", int'(active_o), 1);
    n = 0;
    while (fire_valid_o !== 1'b1 && n < 100) begin frame_i = ($urandom_range(0, 3) != 0); cyc(); n++; end
    chk("fire_wait", int'(n < 100), 1);
    repeat (5) begin
      frame_i = ($urandom_range(0, 3) != 0); cyc();
      chk("hold_valid", int'(fire_valid_o), 1);
      chk("hold_col", int'(fire_col_o), 5);
    end
    fire_ready_i = 1'b1; n = 0;
    while (got.size() < 3 && n < 100) begin
      if (fire_valid_o) got.push_back(int'(fire_col_o));
      frame_i = ($urandom_range(0, 3) != 0); cyc(); n++;
    end
    chk("grant_count", got.size(), 3);
    for (int i = 0; i < 3; i++) if (i < got.size()) chk("grant_col", got[i], exp_cols[i]);

    // Clear mid-march, then async reset in the middle of a drop.
    col_alive_i = 8'h00; cyc();
    chk("clear2_flag", int'(cleared_o), 1);
    chk("clear2_no_fire", int'(fire_valid_o), 0);
    col_alive_i = 8'hFF; start_i = 1'b1; cyc(); start_i = 1'b0;
    n = 0;
    while (m_mode != M_DROP && n < 2000) begin rand_in(); cyc(); n++; end
    chk("drop_wait", int'(n < 2000), 1);
    #2 reset_ni = 1'b0;
    #1 chk_reset_vals("async_rst");
    #2 reset_ni = 1'b1;
    rand_in(); cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
